// File: rtl/proc_led_cmd_reader.sv
// Snoops processor regfile writes to the command register, lights the commanded
// target LED for the commanded time, and reports hit/timeout via valid/ack.
module proc_led_cmd_reader #(
    parameter int unsigned CMD_REG  = 29,
    parameter int unsigned NUM_LEDS = 12,
    parameter int unsigned ON_UNIT  = 100000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                snoop_we,
    input  logic [4:0]          snoop_rd,
    input  logic [31:0]         snoop_data,
    input  logic                btn_hit,
    input  logic                result_ack,
    output logic [NUM_LEDS-1:0] led,
    output logic                target_active,
    output logic                result_valid,
    output logic                result_hit,
    output logic                cmd_err,
    output logic                cmd_overrun
);

    localparam int unsigned PW = (ON_UNIT > 1) ? $clog2(ON_UNIT) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(ON_UNIT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_remaining;
    logic          r_pend_valid;
    logic [3:0]    r_pend_idx;
    logic [15:0]   r_pend_time;

    logic        w_cap;
    logic        w_abort;
    logic [3:0]  w_idx;
    logic [15:0] w_time;
    logic        w_idx_ok;
    logic        w_accept;
    logic        w_reject;
    logic        w_abort_cmd;
    logic        w_pre_wrap;
    logic        w_expire;
    logic        w_pop;
    logic        w_unused_bits;

    // Command decode; an on-time of zero is promoted to one unit.
    assign w_cap         = snoop_we && (snoop_rd == 5'(CMD_REG));
    assign w_abort       = snoop_data[31];
    assign w_idx         = snoop_data[3:0];
    assign w_time        = (snoop_data[19:4] == 16'd0) ? 16'd1 : snoop_data[19:4];
    assign w_idx_ok      = 32'(w_idx) < NUM_LEDS;
    assign w_accept      = w_cap && !w_abort && w_idx_ok;
    assign w_reject      = w_cap && !w_abort && !w_idx_ok;
    assign w_abort_cmd   = w_cap && w_abort;
    assign w_unused_bits = ^snoop_data[30:20];

    assign w_pre_wrap = (r_pre == PRE_LAST);
    assign w_expire   = w_pre_wrap && (r_remaining == 16'd1);

    // Pending entry is consumed when IDLE launches it or ARMED restarts on it.
    assign w_pop = r_pend_valid && !w_abort_cmd &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_ARMED) && !btn_hit && !w_expire));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pre         <= '0;
            r_remaining   <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_idx    <= '0;
            r_pend_time   <= '0;
            led           <= '0;
            target_active <= 1'b0;
            result_valid  <= 1'b0;
            result_hit    <= 1'b0;
            cmd_err       <= 1'b0;
            cmd_overrun   <= 1'b0;
        end else begin
            cmd_err <= w_reject;

            // Single-entry pending buffer, newest command wins.
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_idx   <= w_idx;
                r_pend_time  <= w_time;
                if (r_pend_valid && !w_pop) begin
                    cmd_overrun <= 1'b1;
                end
            end else if (w_pop || (w_abort_cmd && (r_state == S_IDLE))) begin
                r_pend_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state       <= S_ARMED;
                        r_pre         <= '0;
                        r_remaining   <= r_pend_time;
                        led           <= NUM_LEDS'(1) << r_pend_idx;
                        target_active <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_abort_cmd) begin
                        r_state       <= S_IDLE;
                        led           <= '0;
                        target_active <= 1'b0;
                    end else if (btn_hit || w_expire) begin
                        r_state       <= S_REPORT;
                        led           <= '0;
                        target_active <= 1'b0;
                        result_valid  <= 1'b1;
                        result_hit    <= btn_hit;
                    end else if (w_pop) begin
                        r_pre         <= '0;
                        r_remaining   <= r_pend_time;
                        led           <= NUM_LEDS'(1) << r_pend_idx;
                    end else if (w_pre_wrap) begin
                        r_pre         <= '0;
                        r_remaining   <= r_remaining - 16'd1;
                    end else begin
                        r_pre         <= r_pre + PW'(1);
                    end
                end
                S_REPORT: begin
                    if (result_ack) begin
                        r_state      <= S_IDLE;
                        result_valid <= 1'b0;
                        result_hit   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
